median3x3_stage: RTL

- Downstream consumer of the image RAM (2-cycle registered read latency) in the salt-and-pepper noise filter.
- On start, it reads the whole IMG_W x IMG_H 8-bit image in raster order and builds 3x3 windows using two line buffers.
- It computes the 3x3 median through a pipelined sorting network and writes the filtered image to a second image RAM through its write port.

---
 rtl/median3x3_stage.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/median3x3_stage.sv
// median3x3_stage
//   Streams an IMG_W x IMG_H 8-bit image out of a source RAM in raster order.
//   The source RAM has a 2-cycle registered read latency.
//   Two line buffers build 3x3 windows, and a 19-op sorting network in two
//   register stages computes the median. The filtered image is written to a
//   destination RAM. Border pixels pass through unchanged.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     start_i      begin a frame (sampled only while idle)
//     busy_o       frame in progress
//     done_o       one-cycle pulse after the last write
//     rd_en_o      source RAM read enable
//     rd_addr_o    source RAM read address
//     rd_data_i    source RAM data, valid 2 cycles after rd_en_o
//     wr_en_o      destination RAM write enable
//     wr_addr_o    destination RAM write address
//     wr_data_o    filtered pixel
//     corr_cnt_o   (ADAPTIVE_MEDIAN_EN only) pixels replaced this frame
//
//   Optional feature macro: ADAPTIVE_MEDIAN_EN
//     When defined, an interior pixel is replaced by the median only when it
//     is an impulse (0 or 255), and corr_cnt_o counts those replacements.
//     Pipeline timing is the same either way.
module median3x3_stage #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
`ifdef ADAPTIVE_MEDIAN_EN
    ,
    output logic [ADDR_W:0]   corr_cnt_o
`endif
);
    localparam int N  = IMG_W*IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int PW = $clog2(IMG_W+2);   // holds 0..IMG_W+1
    localparam int FW = $clog2(IMG_W+1);   // holds 0..IMG_W
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N-1);

    typedef logic [8:0][7:0] pix9_t;

    // Compare-exchange: smaller value ends up at index a.
    function automatic pix9_t cmpx(input pix9_t p, input int a, input int b);
        pix9_t r;
        r = p;
        if (p[a] > p[b]) begin
            r[a] = p[b];
            r[b] = p[a];
        end
        return r;
    endfunction

    // First 9 ops of the median-of-9 network: sort each row of three.
    function automatic pix9_t net_stage1(input pix9_t p);
        pix9_t r;
        r = p;
        r = cmpx(r, 1, 2); r = cmpx(r, 4, 5); r = cmpx(r, 7, 8);
        r = cmpx(r, 0, 1); r = cmpx(r, 3, 4); r = cmpx(r, 6, 7);
        r = cmpx(r, 1, 2); r = cmpx(r, 4, 5); r = cmpx(r, 7, 8);
        return r;
    endfunction

    // Remaining 10 ops. The median settles in element 4.
    function automatic logic [7:0] net_stage2(input pix9_t p);
        pix9_t r;
        r = p;
        r = cmpx(r, 0, 3); r = cmpx(r, 5, 8); r = cmpx(r, 4, 7);
        r = cmpx(r, 3, 6); r = cmpx(r, 1, 4); r = cmpx(r, 2, 5);
        r = cmpx(r, 4, 7); r = cmpx(r, 4, 2); r = cmpx(r, 6, 4);
        r = cmpx(r, 4, 2);
        return r[4];
    endfunction

    // ------------------------------------------------------------------
    // Control FSM: issues one stream slot per cycle.
    // Slots are real reads during READ and zero-valued dummies during FLUSH.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DRAIN} state_t;

    state_t            state_q;
    logic              busy_q, done_q, rd_en_q, dum_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [FW-1:0]     flush_cnt_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              start_acc;

    assign start_acc = (state_q == S_IDLE) && start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            dum_q       <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_READ;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                S_READ: begin
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_en_q     <= 1'b0;
                        rd_addr_q   <= '0;
                        dum_q       <= 1'b1;
                        flush_cnt_q <= '0;
                        state_q     <= S_FLUSH;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    // IMG_W+1 dummy slots push the last row's centers through.
                    if (flush_cnt_q == FW'(IMG_W)) begin
                        dum_q   <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Finish once the final address leaves the pipeline.
                    if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath.
    // Slot k is issued in cycle k and reaches the window input in cycle k+2.
    // The window, stage 1 and the output register follow in cycles k+3..k+5.
    // ------------------------------------------------------------------
    logic [2:1]            vld_pipe_q, dum_pipe_q;
    logic [7:0]            px_d;
    logic [IMG_W-1:0][7:0] lb1_q, lb2_q;    // rows y-1 and y-2
    logic [2:0][2:0][7:0]  win_q;           // [row][col], col 2 newest
    logic [PW-1:0]         pre_cnt_q;
    logic [XW-1:0]         cx_q;
    logic [YW-1:0]         cy_q;
    logic [ADDR_W-1:0]     caddr_q;
    logic                  win_vld_q, win_bord_q;
    logic [ADDR_W-1:0]     win_addr_q;
    pix9_t                 s1_d, s1_q;
    logic                  s1_vld_q, s1_bord_q;
    logic [7:0]            s1_ctr_q;
    logic [ADDR_W-1:0]     s1_addr_q;
    logic                  repl_d;
    logic [7:0]            res_d;

    assign px_d = dum_pipe_q[2] ? 8'd0 : rd_data_i;

    always_comb begin
        s1_d = net_stage1(pix9_t'(win_q));
    end

    // Interior pixels take the median. In the adaptive build, only impulses do.
`ifdef ADAPTIVE_MEDIAN_EN
    assign repl_d = !s1_bord_q && ((s1_ctr_q == 8'd0) || (s1_ctr_q == 8'hFF));
`else
    assign repl_d = !s1_bord_q;
`endif
    assign res_d = repl_d ? net_stage2(s1_q) : s1_ctr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            dum_pipe_q <= '0;
            lb1_q      <= '0;
            lb2_q      <= '0;
            win_q      <= '0;
            pre_cnt_q  <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            caddr_q    <= '0;
            win_vld_q  <= 1'b0;
            win_bord_q <= 1'b0;
            win_addr_q <= '0;
            s1_q       <= '0;
            s1_vld_q   <= 1'b0;
            s1_bord_q  <= 1'b0;
            s1_ctr_q   <= '0;
            s1_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1], rd_en_q | dum_q};
            dum_pipe_q <= {dum_pipe_q[1], dum_q};

            if (vld_pipe_q[2]) begin
                lb1_q <= {lb1_q[IMG_W-2:0], px_d};
                lb2_q <= {lb2_q[IMG_W-2:0], lb1_q[IMG_W-1]};
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb2_q[IMG_W-1];
                win_q[1][2] <= lb1_q[IMG_W-1];
                win_q[2][2] <= px_d;
            end

            // The first IMG_W+1 slots only prime the buffers. Every later slot
            // puts center c = k-IMG_W-1 in win_q[1][1].
            win_vld_q <= 1'b0;
            if (start_acc) begin
                pre_cnt_q <= '0;
                cx_q      <= '0;
                cy_q      <= '0;
                caddr_q   <= '0;
            end else if (vld_pipe_q[2]) begin
                if (pre_cnt_q != PW'(IMG_W+1)) begin
                    pre_cnt_q <= pre_cnt_q + 1'b1;
                end else begin
                    win_vld_q  <= 1'b1;
                    win_addr_q <= caddr_q;
                    win_bord_q <= (cx_q == '0) || (cx_q == XW'(IMG_W-1)) ||
                                  (cy_q == '0) || (cy_q == YW'(IMG_H-1));
                    if (caddr_q != LAST_ADDR)
                        caddr_q <= caddr_q + 1'b1;
                    if (cx_q == XW'(IMG_W-1)) begin
                        cx_q <= '0;
                        if (cy_q != YW'(IMG_H-1))
                            cy_q <= cy_q + 1'b1;
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                end
            end

            s1_vld_q <= win_vld_q;
            if (win_vld_q) begin
                s1_q      <= s1_d;
                s1_bord_q <= win_bord_q;
                s1_ctr_q  <= win_q[1][1];
                s1_addr_q <= win_addr_q;
            end

            wr_en_q <= s1_vld_q;
            if (s1_vld_q) begin
                wr_addr_q <= s1_addr_q;
                wr_data_q <= res_d;
            end
        end
    end

`ifdef ADAPTIVE_MEDIAN_EN
    logic [ADDR_W:0] corr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            corr_cnt_q <= '0;
        else if (start_acc)
            corr_cnt_q <= '0;
        else if (s1_vld_q && repl_d)
            corr_cnt_q <= corr_cnt_q + 1'b1;
    end

    assign corr_cnt_o = corr_cnt_q;
`endif

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule
